// File: rtl/combinator_pkg.sv
// Shared types and constants for the pixel combinator stage.
// Coordinates and colour widths must match the engine result queues.
package combinator_pkg;

   localparam int DATA_WIDTH    = 10;
   localparam int RGB_SIZE      = 24;
   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   typedef logic [DATA_WIDTH-1:0] coord_t;

   // All-ones never equals a real coordinate, so no queue pops on it.
   localparam coord_t IDLE_COORD = '1;

   typedef struct packed {
      logic [RGB_SIZE-1:0] colour;
      logic                sof;
      logic                eol;
   } pix_t;

endpackage

// File: rtl/pixel_combinator_if.sv
// Ordered pixel stream towards the video-out stage.
// valid/ready handshake with frame and line markers.
interface pixel_combinator_if;
   import combinator_pkg::*;

   logic [RGB_SIZE-1:0] out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_sof;
   logic                out_eol;

   modport master (
      output out_data,
      output out_valid,
      output out_sof,
      output out_eol,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_sof,
      input  out_eol,
      output out_ready
   );

endinterface

// File: rtl/pixel_combinator_skid_fifo.sv
// Two-entry pixel buffer with a registered, first-word-visible head.
// Push and pop in one cycle leave the occupancy unchanged.
module pixel_skid_fifo
   import combinator_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  pix_t       din,
   output pix_t       head,
   output logic [1:0] count
);

   pix_t mem [2];
   logic wr_ptr;
   logic rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr <= !rd_ptr;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/pixel_combinator.sv
// Raster-order pixel combinator: polls engine queues by coordinate
// and re-emits their colours as an ordered pixel stream.
module pixel_combinator
   import combinator_pkg::pix_t,
          combinator_pkg::coord_t,
          combinator_pkg::IDLE_COORD,
          combinator_pkg::RGB_SIZE;
#(
   parameter int NUM_ENGINES   = 4,
   parameter int SCREEN_WIDTH  = combinator_pkg::SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = combinator_pkg::SCREEN_HEIGHT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_ENGINES-1:0]          match_i,
   input  logic [NUM_ENGINES*RGB_SIZE-1:0] colour_i,
   output coord_t                          xpixel_check_o,
   output coord_t                          ypixel_check_o,
   output logic                            frame_done,
   output logic                            multi_hit_err,
   pixel_combinator_if.master              out
);

   localparam coord_t LAST_X = coord_t'(SCREEN_WIDTH - 1);
   localparam coord_t LAST_Y = coord_t'(SCREEN_HEIGHT - 1);
   localparam coord_t ONE    = coord_t'(1);

   function automatic int first_hit(input logic [NUM_ENGINES-1:0] v);
      first_hit = 0;
      for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
         if (v[k]) begin
            first_hit = k;
         end
      end
   endfunction

   logic [NUM_ENGINES-1:0] hit_q;
   coord_t                 cur_x;
   coord_t                 cur_y;
   coord_t                 out_y;
   logic                   run_q;
   logic                   grant;
   logic                   push;
   logic                   pop;
   logic                   last_x;
   logic                   last_y;
   logic [1:0]             count;
   pix_t                   din;
   pix_t                   head;
   int                     sel;

   // Queues pop on the falling edge, so the hit vector is captured there.
   always_ff @(negedge clk) begin
      if (reset) begin
         hit_q <= '0;
      end else begin
         hit_q <= match_i;
      end
   end

   // Request only while a hit this cycle still fits in the buffer.
   assign grant  = run_q && !reset && (count <= 2'd1);
   assign xpixel_check_o = grant ? cur_x : IDLE_COORD;
   assign ypixel_check_o = grant ? cur_y : IDLE_COORD;

   assign last_x = (cur_x == LAST_X);
   assign last_y = (cur_y == LAST_Y);
   assign push   = |hit_q;
   assign pop    = out.out_valid && out.out_ready;

   always_comb begin
      din        = '0;
      sel        = first_hit(hit_q);
      din.colour = colour_i[sel*RGB_SIZE +: RGB_SIZE];
      din.sof    = (cur_x == '0) && (cur_y == '0);
      din.eol    = last_x;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_x         <= '0;
         cur_y         <= '0;
         run_q         <= 1'b0;
         multi_hit_err <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (push) begin
            if (last_x) begin
               cur_x <= '0;
               cur_y <= last_y ? '0 : cur_y + ONE;
            end else begin
               cur_x <= cur_x + ONE;
            end
         end
         if ($countones(hit_q) > 1) begin
            multi_hit_err <= 1'b1;
         end
      end
   end

   pixel_skid_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign out.out_valid = (count != 2'd0);
   assign out.out_data  = head.colour;
   assign out.out_sof   = out.out_valid && head.sof;
   assign out.out_eol   = out.out_valid && head.eol;

   // Output-side line count tells which end-of-line closes the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_y      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && head.eol && (out_y == LAST_Y);
         if (pop && head.eol) begin
            out_y <= (out_y == LAST_Y) ? '0 : out_y + ONE;
         end
      end
   end

endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator with model queues
// and a raster-order scoreboard on the output stream.
module tb_pixel_combinator;
  import combinator_pkg::*;

  localparam int NE   = 4;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int QD   = 512;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NE-1:0]          match;
  logic [NE*RGB_SIZE-1:0] colour;
  coord_t                 cx;
  coord_t                 cy;
  logic                   frame_done;
  logic                   mhe;

  always #5 clk = ~clk;

  pixel_combinator_if bus ();

  pixel_combinator #(
    .NUM_ENGINES   (NE),
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .match_i        (match),
    .colour_i       (colour),
    .xpixel_check_o (cx),
    .ypixel_check_o (cy),
    .frame_done     (frame_done),
    .multi_hit_err  (mhe),
    .out            (bus)
  );

  coord_t              qx [NE][QD];
  coord_t              qy [NE][QD];
  logic [RGB_SIZE-1:0] qc [NE][QD];
  int                  qh [NE];
  int                  qt [NE];
  logic [RGB_SIZE-1:0] creg [NE];
  logic [RGB_SIZE-1:0] ctab [NPIX];

  initial begin
    for (int k = 0; k < NE; k++) begin
      qt[k] = 0;
    end
  end

  initial begin
    for (int k = 0; k < NE; k++) begin
      qh[k]   <= 0;
      creg[k] <= '0;
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < NE; k++) begin
      if (qh[k] < qt[k]) begin
        if (qx[k][qh[k]] == cx &&
            qy[k][qh[k]] == cy) begin
          match[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    colour = '0;
    for (int k = 0; k < NE; k++) begin
      colour[k*RGB_SIZE +: RGB_SIZE] = creg[k];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NE; k++) begin
      if (match[k]) begin
        creg[k] <= qc[k][qh[k]];
        qh[k]   <= qh[k] + 1;
      end
    end
  end

  int tests     = 0;
  int fails     = 0;
  int acc_cnt   = 0;
  int fd_cnt    = 0;
  int exp_idx   = 0;
  int cyc       = 0;
  int first_acc = 0;
  int last_acc  = 0;
  logic fd_exp  = 1'b0;
  logic stall_q = 1'b0;
  logic [RGB_SIZE+1:0] held = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_idx = 0;
      fd_exp  = 1'b0;
      stall_q = 1'b0;
    end else begin
      tests++;
      if (frame_done !== fd_exp) begin
        fails++;
        $error("FAIL frame_done observed=%0h expected=%0h",
               frame_done, fd_exp);
      end
      fd_exp = 1'b0;
      if (frame_done) fd_cnt++;
      if (stall_q) begin
        tests++;
        if (bus.out_valid !== 1'b1) begin
          fails++;
          $error("FAIL hold_valid observed=%0h expected=1",
                 bus.out_valid);
        end
        tests++;
        if ({bus.out_data, bus.out_sof, bus.out_eol} !== held) begin
          fails++;
          $error("FAIL hold_data observed=%0h expected=%0h",
                 {bus.out_data, bus.out_sof, bus.out_eol}, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (bus.out_data !== ctab[exp_idx]) begin
          fails++;
          $error("FAIL pix_data observed=%0h expected=%0h",
                 bus.out_data, ctab[exp_idx]);
        end
        tests++;
        if (bus.out_sof !== (exp_idx == 0)) begin
          fails++;
          $error("FAIL pix_sof observed=%0h expected=%0h",
                 bus.out_sof, (exp_idx == 0));
        end
        tests++;
        if (bus.out_eol !== ((exp_idx % W) == W - 1)) begin
          fails++;
          $error("FAIL pix_eol observed=%0h expected=%0h",
                 bus.out_eol, ((exp_idx % W) == W - 1));
        end
        fd_exp  = (exp_idx == NPIX - 1);
        exp_idx = (exp_idx + 1) % NPIX;
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held    = {bus.out_data, bus.out_sof, bus.out_eol};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic put(input int k, input int x, input int y,
                     input logic [RGB_SIZE-1:0] c);
    qx[k][qt[k]] = coord_t'(x);
    qy[k][qt[k]] = coord_t'(y);
    qc[k][qt[k]] = c;
    qt[k]++;
  endtask

  task automatic flush();
    for (int k = 0; k < NE; k++) begin
      qt[k] = qh[k];
    end
  endtask

  function automatic int heads();
    int s = 0;
    for (int k = 0; k < NE; k++) s += qh[k];
    return s;
  endfunction

  task automatic load_frame();
    for (int i = 0; i < NPIX; i++) begin
      ctab[i] = RGB_SIZE'($urandom);
      put($urandom_range(NE - 1, 0), i % W, i / W, ctab[i]);
    end
  endtask

  task automatic rst();
    @(posedge clk);
    #1 reset = 1'b1;
    flush();
    acc_cnt = 0;
    fd_cnt  = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c = 0;
    while (acc_cnt < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    tests++;
    if (acc_cnt < n) begin
      fails++;
      $error("FAIL wait_acc observed=%0d expected=%0d",
             acc_cnt, n);
    end
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $error("FAIL rst_valid observed=%0h expected=0",
             bus.out_valid);
    end
    tests++;
    if (bus.out_sof !== 1'b0) begin
      fails++;
      $error("FAIL rst_sof observed=%0h expected=0", bus.out_sof);
    end
    tests++;
    if (bus.out_eol !== 1'b0) begin
      fails++;
      $error("FAIL rst_eol observed=%0h expected=0", bus.out_eol);
    end
    tests++;
    if (cx !== IDLE_COORD) begin
      fails++;
      $error("FAIL rst_cx observed=%0h expected=%0h",
             cx, IDLE_COORD);
    end
    tests++;
    if (cy !== IDLE_COORD) begin
      fails++;
      $error("FAIL rst_cy observed=%0h expected=%0h",
             cy, IDLE_COORD);
    end
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $error("FAIL rst_fd observed=%0h expected=0", frame_done);
    end
    tests++;
    if (mhe !== 1'b0) begin
      fails++;
      $error("FAIL rst_mhe observed=%0h expected=0", mhe);
    end

    for (int i = 0; i < 4; i++) begin
      ctab[i] = RGB_SIZE'(32'h10 + i);
      put(0, i, 0, ctab[i]);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_acc(4, 50);
    settle();
    tests++;
    if (acc_cnt !== 4) begin
      fails++;
      $error("FAIL t2_count observed=%0d expected=4", acc_cnt);
    end
    tests++;
    if (last_acc - first_acc !== 3) begin
      fails++;
      $error("FAIL t2_rate observed=%0d expected=3",
             last_acc - first_acc);
    end
    tests++;
    if (cx !== coord_t'(4)) begin
      fails++;
      $error("FAIL t2_cx observed=%0h expected=4", cx);
    end
    tests++;
    if (cy !== coord_t'(0)) begin
      fails++;
      $error("FAIL t2_cy observed=%0h expected=0", cy);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $error("FAIL t2_valid observed=%0h expected=0",
             bus.out_valid);
    end

    rst();
    load_frame();
    wait_acc(NPIX, 400);
    settle();
    tests++;
    if (acc_cnt !== NPIX) begin
      fails++;
      $error("FAIL t3_count observed=%0d expected=%0d",
             acc_cnt, NPIX);
    end
    tests++;
    if (last_acc - first_acc !== NPIX - 1) begin
      fails++;
      $error("FAIL t3_rate observed=%0d expected=%0d",
             last_acc - first_acc, NPIX - 1);
    end
    tests++;
    if (fd_cnt !== 1) begin
      fails++;
      $error("FAIL t3_fd observed=%0d expected=1", fd_cnt);
    end
    tests++;
    if (cx !== coord_t'(0)) begin
      fails++;
      $error("FAIL t3_cx observed=%0h expected=0", cx);
    end
    tests++;
    if (cy !== coord_t'(0)) begin
      fails++;
      $error("FAIL t3_cy observed=%0h expected=0", cy);
    end

    rst();
    load_frame();
    wait_acc(5, 100);
    bus.out_ready = 1'b0;
    begin
      int hs;
      int as;
      repeat (3) @(posedge clk);
      #1 hs = heads();
      as = acc_cnt;
      repeat (7) @(posedge clk);
      #1;
      tests++;
      if (heads() !== hs) begin
        fails++;
        $error("FAIL t4_nopop observed=%0d expected=%0d",
               heads(), hs);
      end
      tests++;
      if (acc_cnt !== as) begin
        fails++;
        $error("FAIL t4_noacc observed=%0d expected=%0d",
               acc_cnt, as);
      end
      tests++;
      if (bus.out_valid !== 1'b1) begin
        fails++;
        $error("FAIL t4_full observed=%0h expected=1",
               bus.out_valid);
      end
      tests++;
      if (cx !== IDLE_COORD) begin
        fails++;
        $error("FAIL t4_idle_x observed=%0h expected=%0h",
               cx, IDLE_COORD);
      end
      tests++;
      if (cy !== IDLE_COORD) begin
        fails++;
        $error("FAIL t4_idle_y observed=%0h expected=%0h",
               cy, IDLE_COORD);
      end
    end
    for (int c = 0; c < 1000 && acc_cnt < NPIX; c++) begin
      @(posedge clk);
      #1 bus.out_ready = 1'($urandom_range(1, 0));
    end
    bus.out_ready = 1'b1;
    settle();
    tests++;
    if (acc_cnt !== NPIX) begin
      fails++;
      $error("FAIL t4_count observed=%0d expected=%0d",
             acc_cnt, NPIX);
    end
    tests++;
    if (fd_cnt !== 1) begin
      fails++;
      $error("FAIL t4_fd observed=%0d expected=1", fd_cnt);
    end

    rst();
    for (int i = 0; i < NPIX; i++) begin
      ctab[i] = RGB_SIZE'($urandom);
      if (i < 5) put(1, i % W, i / W, ctab[i]);
      else if (i > 5) put(3, i % W, i / W, ctab[i]);
    end
    put(0, 5, 0, ctab[5]);
    put(2, 5, 0, ~ctab[5]);
    wait_acc(3, 50);
    tests++;
    if (mhe !== 1'b0) begin
      fails++;
      $error("FAIL t5_mhe_pre observed=%0h expected=0", mhe);
    end
    wait_acc(NPIX, 400);
    settle();
    tests++;
    if (acc_cnt !== NPIX) begin
      fails++;
      $error("FAIL t5_count observed=%0d expected=%0d",
             acc_cnt, NPIX);
    end
    tests++;
    if (mhe !== 1'b1) begin
      fails++;
      $error("FAIL t5_mhe observed=%0h expected=1", mhe);
    end
    tests++;
    if (qh[2] !== qt[2]) begin
      fails++;
      $error("FAIL t5_q2_pop observed=%0d expected=%0d",
             qh[2], qt[2]);
    end

    rst();
    load_frame();
    wait_acc(19, 200);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $error("FAIL t6_full observed=%0h expected=1",
             bus.out_valid);
    end
    tests++;
    if (cx !== IDLE_COORD) begin
      fails++;
      $error("FAIL t6_idle observed=%0h expected=%0h",
             cx, IDLE_COORD);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    flush();
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $error("FAIL t6_valid observed=%0h expected=0",
             bus.out_valid);
    end
    tests++;
    if (cx !== IDLE_COORD) begin
      fails++;
      $error("FAIL t6_cx_idle observed=%0h expected=%0h",
             cx, IDLE_COORD);
    end
    tests++;
    if (mhe !== 1'b0) begin
      fails++;
      $error("FAIL t6_mhe observed=%0h expected=0", mhe);
    end
    @(negedge clk);
    tests++;
    if (cx !== coord_t'(0)) begin
      fails++;
      $error("FAIL t6_cx0 observed=%0h expected=0", cx);
    end
    tests++;
    if (cy !== coord_t'(0)) begin
      fails++;
      $error("FAIL t6_cy0 observed=%0h expected=0", cy);
    end
    @(posedge clk);
    #1;
    acc_cnt = 0;
    fd_cnt  = 0;
    bus.out_ready = 1'b1;
    load_frame();
    wait_acc(NPIX, 400);
    settle();
    tests++;
    if (acc_cnt !== NPIX) begin
      fails++;
      $error("FAIL t6_count observed=%0d expected=%0d",
             acc_cnt, NPIX);
    end
    tests++;
    if (fd_cnt !== 1) begin
      fails++;
      $error("FAIL t6_fd observed=%0d expected=1", fd_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
